instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader.sv | 130 +++++++++++++
 tb/tb_instr_loader.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Byte-stream instruction loader: assembles high-byte-first 16-bit words from a
// valid/ready byte stream and writes them to instruction memory while holding the CPU.
module instr_loader #(
  parameter int N = 16,
  parameter int A = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [A:0]   len,
  input  logic         abort,
  input  logic         in_valid,
  input  logic [7:0]   in_byte,
  output logic         in_ready,
  output logic         wr_en,
  output logic [A-1:0] wr_addr,
  output logic [N-1:0] wr_data,
  output logic         cpu_hold,
  output logic         done,
  output logic         err,
  output logic [A:0]   words_written,
  output logic [N-1:0] checksum
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HI    = 3'd1,
    LO    = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [A:0]   MAX_LEN = {1'b1, {A{1'b0}}};
  localparam logic [A:0]   ONE_W   = {{A{1'b0}}, 1'b1};
  localparam logic [A-1:0] ONE_A   = {{(A-1){1'b0}}, 1'b1};

  state_t       state;
  logic [A:0]   len_q;
  logic [A-1:0] addr_q;
  logic [7:0]   hi_q;
  logic [N-1:0] word_q;
  logic [A:0]   cnt_q;
  logic [N-1:0] sum_q;
  logic         err_q;

  logic         len_ok;
  logic [A:0]   cnt_inc;

  assign len_ok  = (len != '0) && (len <= MAX_LEN);
  assign cnt_inc = cnt_q + ONE_W;

  // NOTE: wr_en and in_ready look at abort combinationally so an abort in the
  // same cycle suppresses the write and refuses the byte before the edge.
  assign in_ready = ((state == HI) || (state == LO)) && !abort;
  assign wr_en    = (state == WRITE) && !abort;
  assign cpu_hold = (state != IDLE);
  assign done     = (state == DONE);
  assign err      = err_q;

  assign wr_addr       = addr_q;
  assign wr_data       = word_q;
  assign words_written = cnt_q;
  assign checksum      = sum_q;

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      len_q  <= '0;
      addr_q <= '0;
      hi_q   <= '0;
      word_q <= '0;
      cnt_q  <= '0;
      sum_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (len_ok) begin
              len_q  <= len;
              addr_q <= '0;
              cnt_q  <= '0;
              sum_q  <= '0;
              state  <= HI;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        HI: begin
          if (abort) begin
            state <= IDLE;
          end else if (in_valid) begin
            hi_q  <= in_byte;
            state <= LO;
          end
        end
        LO: begin
          if (abort) begin
            state <= IDLE;
          end else if (in_valid) begin
            word_q <= {hi_q, in_byte};
            state  <= WRITE;
          end
        end
        WRITE: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            cnt_q <= cnt_inc;
            sum_q <= sum_q + word_q;
            // Last word stops without bumping the address, so len=2^A never wraps.
            if (cnt_inc == len_q) begin
              state <= DONE;
            end else begin
              addr_q <= addr_q + ONE_A;
              state  <= HI;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: randomized byte streams scored against a
// word-level model (expected writes, addresses, timing and checksum from the byte list).
module tb_instr_loader;

  localparam int N = 16;
  localparam int A = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [A:0]   len = '0;
  logic         abort = 1'b0;
  logic         in_valid = 1'b0;
  logic [7:0]   in_byte = '0;
  logic         in_ready;
  logic         wr_en;
  logic [A-1:0] wr_addr;
  logic [N-1:0] wr_data;
  logic         cpu_hold;
  logic         done;
  logic         err;
  logic [A:0]   words_written;
  logic [N-1:0] checksum;

  int total = 0;
  int bad   = 0;

  logic [15:0]  tx_words    [0:1023];
  int           wr_cyc      [0:1023];
  logic [A-1:0] wr_addr_log [0:1023];
  logic [15:0]  wr_data_log [0:1023];
  int           byte_cyc    [0:2047];
  int           n_wr, n_done, n_err;
  bit           hold_ok;

  instr_loader #(.N(N), .A(A)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .len           (len),
    .abort         (abort),
    .in_valid      (in_valid),
    .in_byte       (in_byte),
    .in_ready      (in_ready),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .cpu_hold      (cpu_hold),
    .done          (done),
    .err           (err),
    .words_written (words_written),
    .checksum      (checksum)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] byte_of(input int idx);
    logic [15:0] w;
    w = tx_words[idx / 2];
    return (idx % 2 == 0) ? w[15:8] : w[7:0];
  endfunction

  function automatic logic [15:0] sum_words(input int n);
    logic [15:0] s;
    s = '0;
    for (int i = 0; i < n; i++) s = s + tx_words[i];
    return s;
  endfunction

  // Drives one load from tx_words and scores every write against the byte list.
  task automatic run_load(input int nlen, input int valid_pct, input int abort_at, input bit noise);
    int idx, nbytes, stream_errs, timing_errs, spacing_errs;
    bit abort_now, abort_fired;
    idx = 0; nbytes = 2 * nlen; abort_fired = 0;
    n_wr = 0; n_done = 0; n_err = 0; hold_ok = 1;
    start = 1'b1; len = nlen[A:0]; abort = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 4 * nlen + 64; c++) begin
      abort_now = (abort_at >= 0) && (idx == abort_at) && !abort_fired;
      abort = abort_now;
      if (abort_now) abort_fired = 1;
      in_valid = (idx < nbytes) && ($urandom_range(99) < valid_pct);
      in_byte  = (idx < nbytes) ? byte_of(idx) : 8'($urandom);
      if (noise) begin
        start = 1'($urandom_range(1));
        len   = (A+1)'($urandom);
      end
      @(negedge clk);
      if (cpu_hold !== 1'b1) hold_ok = 0;
      if (in_valid && in_ready === 1'b1) begin
        if (idx < 2048) byte_cyc[idx] = c;
        idx++;
      end
      if (wr_en === 1'b1) begin
        if (n_wr < 1024) begin
          wr_cyc[n_wr]      = c;
          wr_addr_log[n_wr] = wr_addr;
          wr_data_log[n_wr] = wr_data;
        end
        n_wr++;
      end
      if (done === 1'b1) n_done++;
      if (err === 1'b1) n_err++;
      @(posedge clk); #1;
      if (n_done != 0 || abort_now) break;
    end
    start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (cpu_hold !== 1'b0) begin
      bad++; $display("FAIL hold_after_load: got %0b expected 0", cpu_hold);
    end
    stream_errs = 0; timing_errs = 0; spacing_errs = 0;
    for (int i = 0; i < n_wr && i < 1024; i++) begin
      if (wr_addr_log[i] !== i[A-1:0] || wr_data_log[i] !== tx_words[i]) stream_errs++;
      if (wr_cyc[i] != byte_cyc[2 * i + 1] + 1) timing_errs++;
      if (i > 0 && wr_cyc[i] - wr_cyc[i - 1] != 3) spacing_errs++;
    end
    total++;
    if (stream_errs !== 0) begin
      bad++; $display("FAIL write_stream: got %0d bad addr/data writes expected 0", stream_errs);
    end
    total++;
    if (timing_errs !== 0) begin
      bad++; $display("FAIL write_latency: got %0d late writes expected 0", timing_errs);
    end
    if (valid_pct == 100) begin
      total++;
      if (spacing_errs !== 0) begin
        bad++; $display("FAIL throughput: got %0d gaps not equal 3 expected 0", spacing_errs);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err, words_written, checksum} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got rdy=%0b we=%0b a=%0h d=%0h hold=%0b done=%0b err=%0b ww=%0d cs=%0h expected all 0",
               in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err, words_written, checksum);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (cpu_hold !== 1'b0 || in_ready !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset: got hold=%0b rdy=%0b expected 0 0", cpu_hold, in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    tx_words[0] = 16'h1234;
    tx_words[1] = 16'hABCD;
    run_load(2, 100, -1, 0);
    total++;
    if (n_wr !== 2) begin bad++; $display("FAIL basic_writes: got %0d expected 2", n_wr); end
    total++;
    if (n_done !== 1) begin bad++; $display("FAIL basic_done: got %0d expected 1", n_done); end
    total++;
    if (words_written !== 11'd2) begin
      bad++; $display("FAIL basic_words: got %0d expected 2", words_written);
    end
    total++;
    if (checksum !== 16'hBE01) begin
      bad++; $display("FAIL basic_checksum: got %0h expected be01", checksum);
    end
  endtask

  task automatic test_illegal_len();
    logic [A:0]   lens [2];
    logic [A:0]   ww0;
    logic [N-1:0] cs0;
    int errs, wrs, holds;
    lens[0] = 11'd0;
    lens[1] = 11'd1025;
    for (int k = 0; k < 2; k++) begin
      ww0 = words_written; cs0 = checksum;
      errs = 0; wrs = 0; holds = 0;
      start = 1'b1; len = lens[k];
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) begin
        @(negedge clk);
        if (err === 1'b1) errs++;
        if (wr_en !== 1'b0) wrs++;
        if (cpu_hold !== 1'b0) holds++;
      end
      total++;
      if (errs !== 1) begin bad++; $display("FAIL illegal_err len=%0d: got %0d pulses expected 1", lens[k], errs); end
      total++;
      if (wrs !== 0 || holds !== 0) begin
        bad++; $display("FAIL illegal_quiet len=%0d: got wr=%0d hold=%0d expected 0 0", lens[k], wrs, holds);
      end
      total++;
      if (words_written !== ww0 || checksum !== cs0) begin
        bad++; $display("FAIL illegal_counters len=%0d: got ww=%0d cs=%0h expected %0d %0h",
                        lens[k], words_written, checksum, ww0, cs0);
      end
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 8; i++) tx_words[i] = 16'($urandom);
    run_load(8, 45, -1, 1);
    total++;
    if (n_wr !== 8 || n_done !== 1) begin
      bad++; $display("FAIL bp_writes: got writes=%0d done=%0d expected 8 1", n_wr, n_done);
    end
    total++;
    if (!hold_ok) begin bad++; $display("FAIL bp_hold: got hold low during load expected 1"); end
    total++;
    if (words_written !== 11'd8 || checksum !== sum_words(8)) begin
      bad++; $display("FAIL bp_counters: got ww=%0d cs=%0h expected 8 %0h", words_written, checksum, sum_words(8));
    end
  endtask

  task automatic test_abort();
    logic [15:0] cs_exp;
    // Abort after the high byte of word 3: two full words remain written.
    for (int i = 0; i < 5; i++) tx_words[i] = 16'($urandom);
    cs_exp = sum_words(2);
    run_load(5, 70, 5, 0);
    total++;
    if (n_wr !== 2 || n_done !== 0 || n_err !== 0) begin
      bad++; $display("FAIL abort_lo: got writes=%0d done=%0d err=%0d expected 2 0 0", n_wr, n_done, n_err);
    end
    total++;
    if (words_written !== 11'd2 || checksum !== cs_exp) begin
      bad++; $display("FAIL abort_lo_counters: got ww=%0d cs=%0h expected 2 %0h", words_written, checksum, cs_exp);
    end
    tx_words[0] = 16'hFFFF;
    run_load(1, 100, -1, 0);
    total++;
    if (n_wr !== 1 || n_done !== 1 || words_written !== 11'd1 || checksum !== 16'hFFFF) begin
      bad++; $display("FAIL reload: got writes=%0d done=%0d ww=%0d cs=%0h expected 1 1 1 ffff",
                      n_wr, n_done, words_written, checksum);
    end
    // Abort landing on the first WRITE cycle must swallow that write.
    for (int i = 0; i < 3; i++) tx_words[i] = 16'($urandom);
    run_load(3, 100, 2, 0);
    total++;
    if (n_wr !== 0 || n_done !== 0 || words_written !== 11'd0 || checksum !== 16'h0000) begin
      bad++; $display("FAIL abort_write: got writes=%0d done=%0d ww=%0d cs=%0h expected 0 0 0 0",
                      n_wr, n_done, words_written, checksum);
    end
  endtask

  task automatic test_full_memory();
    for (int i = 0; i < 1024; i++) tx_words[i] = 16'(i);
    run_load(1024, 100, -1, 0);
    total++;
    if (n_wr !== 1024 || n_done !== 1) begin
      bad++; $display("FAIL full_writes: got writes=%0d done=%0d expected 1024 1", n_wr, n_done);
    end
    total++;
    if (wr_addr_log[1023] !== 10'h3FF) begin
      bad++; $display("FAIL full_last_addr: got %0h expected 3ff", wr_addr_log[1023]);
    end
    total++;
    if (words_written !== 11'd1024 || checksum !== 16'hFE00) begin
      bad++; $display("FAIL full_counters: got ww=%0d cs=%0h expected 1024 fe00", words_written, checksum);
    end
  endtask

  task automatic test_reset_mid_load();
    bit seen;
    int stray;
    seen = 0; stray = 0;
    start = 1'b1; len = 11'd4;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 20 && !seen; c++) begin
      in_byte = 8'($urandom);
      @(negedge clk);
      if (wr_en === 1'b1) seen = 1;
      else begin @(posedge clk); #1; end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL rst_mid_reach_write: got no write expected one"); end
    #1 rst = 1'b0;
    #1;
    total++;
    if ({in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err, words_written, checksum} !== '0) begin
      bad++;
      $display("FAIL rst_mid_outputs: got we=%0b a=%0h d=%0h hold=%0b ww=%0d cs=%0h expected all 0",
               wr_en, wr_addr, wr_data, cpu_hold, words_written, checksum);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (wr_en !== 1'b0 || cpu_hold !== 1'b0) stray++;
    end
    in_valid = 1'b0;
    total++;
    if (stray !== 0) begin bad++; $display("FAIL rst_mid_idle: got %0d busy cycles expected 0", stray); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_illegal_len();
    test_backpressure();
    test_abort();
    test_full_memory();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
